// File: rtl/axi_read_arbiter_if.sv
// Signal bundle between the refill requesters, the read arbiter and the AXI read port.
// The arbiter takes the slave view; requesters plus AXI bridge together take the master view.
interface axi_read_arbiter_if #(
    parameter int NUM_M  = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NUM_M*ADDR_W-1:0] m_araddr_i;
    logic [NUM_M*4-1:0]      m_arlen_i;
    logic [NUM_M-1:0]        m_arvalid_i;
    logic [NUM_M-1:0]        m_arready_o;
    logic [DATA_W-1:0]       m_rdata_o;
    logic [NUM_M-1:0]        m_rvalid_o;
    logic [NUM_M-1:0]        m_rlast_o;
    logic [NUM_M-1:0]        m_rready_i;

    logic [ADDR_W-1:0]       axi_araddr_o;
    logic [3:0]              axi_arlen_o;
    logic [2:0]              axi_arsize_o;
    logic [1:0]              axi_arburst_o;
    logic                    axi_arvalid_o;
    logic                    axi_arready_i;
    logic [DATA_W-1:0]       axi_rdata_i;
    logic                    axi_rvalid_i;
    logic                    axi_rlast_i;
    logic                    axi_rready_o;

    modport slave (
        input  m_araddr_i, m_arlen_i, m_arvalid_i, m_rready_i,
               axi_arready_i, axi_rdata_i, axi_rvalid_i, axi_rlast_i,
        output m_arready_o, m_rdata_o, m_rvalid_o, m_rlast_o,
               axi_araddr_o, axi_arlen_o, axi_arsize_o, axi_arburst_o,
               axi_arvalid_o, axi_rready_o
    );

    modport master (
        output m_araddr_i, m_arlen_i, m_arvalid_i, m_rready_i,
               axi_arready_i, axi_rdata_i, axi_rvalid_i, axi_rlast_i,
        input  m_arready_o, m_rdata_o, m_rvalid_o, m_rlast_o,
               axi_araddr_o, axi_arlen_o, axi_arsize_o, axi_arburst_o,
               axi_arvalid_o, axi_rready_o
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read channel between dcache refill, icache refill and the prefetcher.
// Fixed priority with a starvation guard for the last (prefetch) master; one burst in flight.
module axi_read_arbiter #(
    parameter int NUM_M        = 3,
    parameter int STARVE_LIMIT = 16,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic              clock,
    input  logic              resetn,
    axi_read_arbiter_if.slave bus,
    output logic [NUM_M-1:0]  grant_o,
    output logic              busy_o,
    output logic              err_o
);
    localparam int WAIT_W   = $clog2(STARVE_LIMIT + 1);
    localparam int IDX_W    = $clog2(NUM_M);
    localparam int STARVE_M = NUM_M - 1;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_READ} state_t;

    state_t              state_q, state_d;
    logic [NUM_M-1:0]    grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          len_q, len_d;
    logic [3:0]          beat_q, beat_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                err_q, err_d;

    logic [NUM_M-1:0]    winner;
    logic [IDX_W-1:0]    win_idx;
    logic                beat;

    // The starved prefetcher overrides priority; otherwise the lowest requesting index wins.
    always_comb begin
        winner  = '0;
        win_idx = '0;
        if (wait_q == WAIT_W'(STARVE_LIMIT) && bus.m_arvalid_i[STARVE_M]) begin
            winner[STARVE_M] = 1'b1;
            win_idx          = IDX_W'(STARVE_M);
        end else begin
            for (int m = NUM_M - 1; m >= 0; m--) begin
                if (bus.m_arvalid_i[m]) begin
                    winner    = '0;
                    winner[m] = 1'b1;
                    win_idx   = IDX_W'(m);
                end
            end
        end
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path infers a latch.
        state_d           = state_q;
        grant_d           = grant_q;
        addr_d            = addr_q;
        len_d             = len_q;
        beat_d            = beat_q;
        err_d             = err_q;
        beat              = 1'b0;
        bus.axi_arvalid_o = 1'b0;
        bus.axi_rready_o  = 1'b0;
        bus.m_arready_o   = '0;
        bus.m_rvalid_o    = '0;
        bus.m_rlast_o     = '0;

        case (state_q)
            S_IDLE: begin
                if (|winner) begin
                    addr_d  = bus.m_araddr_i[win_idx*ADDR_W +: ADDR_W];
                    len_d   = bus.m_arlen_i[win_idx*4 +: 4];
                    grant_d = winner;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                bus.axi_arvalid_o = 1'b1;
                if (bus.axi_arready_i) begin
                    bus.m_arready_o = grant_q;
                    beat_d          = '0;
                    state_d         = S_READ;
                end
            end
            S_READ: begin
                bus.axi_rready_o = |(bus.m_rready_i & grant_q);
                bus.m_rvalid_o   = grant_q & {NUM_M{bus.axi_rvalid_i}};
                bus.m_rlast_o    = grant_q & {NUM_M{bus.axi_rlast_i}};
                beat             = bus.axi_rvalid_i & bus.axi_rready_o;
                if (beat) begin
                    beat_d = beat_q + 4'd1;
                    if (bus.axi_rlast_i) begin
                        if (beat_q != len_q) err_d = 1'b1;
                        grant_d = '0;
                        state_d = S_IDLE;
                    end else if (beat_q == len_q) begin
                        // Slave ran past the requested length; keep draining until rlast.
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Prefetch wait counter: counts while it requests without owning the channel.
    always_comb begin
        wait_d = wait_q;
        if (!bus.m_arvalid_i[STARVE_M] || grant_q[STARVE_M] ||
            (state_q == S_IDLE && winner[STARVE_M])) begin
            wait_d = '0;
        end else if (wait_q != WAIT_W'(STARVE_LIMIT)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign bus.axi_araddr_o  = addr_q;
    assign bus.axi_arlen_o   = len_q;
    assign bus.axi_arsize_o  = 3'b010;
    assign bus.axi_arburst_o = 2'b01;
    assign bus.m_rdata_o     = DATA_W'(bus.axi_rdata_i);
    assign grant_o           = grant_q;
    assign busy_o            = (state_q != S_IDLE);
    assign err_o             = err_q;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: requester models, a small AXI slave and a beat monitor.
module tb_axi_read_arbiter;
    logic       clock  = 1'b0;
    logic       resetn = 1'b1;
    logic [2:0] grant;
    logic       busy;
    logic       err;

    always #5 clock = ~clock;

    axi_read_arbiter_if #(.NUM_M(3), .ADDR_W(32), .DATA_W(32)) bus ();

    axi_read_arbiter #(.NUM_M(3), .STARVE_LIMIT(16), .ADDR_W(32), .DATA_W(32)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .bus     (bus.slave),
        .grant_o (grant),
        .busy_o  (busy),
        .err_o   (err)
    );

    int checks   = 0;
    int failures = 0;

    // Requesters: a master holds arvalid while it has issued more bursts than were accepted.
    int          issued [3] = '{0, 0, 0};
    int          done   [3] = '{0, 0, 0};
    logic [31:0] req_addr [3];
    logic [3:0]  req_len  [3];

    for (genvar g = 0; g < 3; g++) begin : g_req
        assign bus.m_arvalid_i[g]          = (issued[g] != done[g]);
        assign bus.m_araddr_i[g*32 +: 32]  = req_addr[g];
        assign bus.m_arlen_i[g*4 +: 4]     = req_len[g];
    end

    // Monitor state, sampled on the rising edge.
    int          ar_cnt [3]      = '{0, 0, 0};
    int          beats [3]       = '{0, 0, 0};
    int          burst_beats [3] = '{0, 0, 0};
    int          rlast_cnt [3]   = '{0, 0, 0};
    int          rlast_at [3]    = '{0, 0, 0};
    logic [31:0] last_data [3];
    int          order [64]      = '{default: -1};
    int          order_n = 0, stray = 0, ar_wait_cyc = 0, unstable = 0, bad_pulse = 0;
    logic [31:0] cap_addr = '0, prev_addr = '0;
    logic [3:0]  cap_len = '0;
    logic        prev_arvalid = 1'b0, prev_arready = 1'b0;
    logic        ar_hs = 1'b0, r_hs = 1'b0;

    always @(posedge clock) begin
        ar_hs <= bus.axi_arvalid_o & bus.axi_arready_i;
        r_hs  <= bus.axi_rvalid_i & bus.axi_rready_o;
        if (bus.axi_arvalid_o && bus.axi_arready_i) begin
            cap_addr <= bus.axi_araddr_o;
            cap_len  <= bus.axi_arlen_o;
        end
        if ((|bus.m_arready_o) && order_n < 64) begin
            order_n <= order_n + 1;
            for (int m = 0; m < 3; m++)
                if (bus.m_arready_o[m]) order[order_n] <= m;
        end
        for (int m = 0; m < 3; m++) begin
            if (bus.m_arready_o[m]) begin
                done[m]        <= done[m] + 1;
                ar_cnt[m]      <= ar_cnt[m] + 1;
                burst_beats[m] <= 0;
            end
            if (bus.m_rvalid_o[m] && bus.m_rready_i[m]) begin
                beats[m]       <= beats[m] + 1;
                burst_beats[m] <= burst_beats[m] + 1;
                if (bus.m_rlast_o[m]) begin
                    rlast_cnt[m] <= rlast_cnt[m] + 1;
                    rlast_at[m]  <= burst_beats[m] + 1;
                    last_data[m] <= bus.m_rdata_o;
                end
            end
        end
        if (((bus.m_rvalid_o | bus.m_rlast_o | bus.m_arready_o) & ~grant) != 3'b000 ||
            $countones(grant) > 1)
            stray <= stray + 1;
        if (bus.axi_arvalid_o && !bus.axi_arready_i) ar_wait_cyc <= ar_wait_cyc + 1;
        if (prev_arvalid && !prev_arready && bus.axi_arvalid_o && bus.axi_araddr_o != prev_addr)
            unstable <= unstable + 1;
        if ((|bus.m_arready_o) && !(bus.axi_arvalid_o && bus.axi_arready_i))
            bad_pulse <= bad_pulse + 1;
        prev_arvalid <= bus.axi_arvalid_o;
        prev_arready <= bus.axi_arready_i;
        prev_addr    <= bus.axi_araddr_o;
    end

    // AXI slave: configurable AR delay, beat count override; data = address + 4*beat.
    int          cfg_ar_delay = 0;
    int          cfg_beats    = 0;
    int          ar_wait = 0, s_total = 0, s_idx = 0;
    logic [31:0] s_addr = '0;

    always @(negedge clock or negedge resetn) begin
        if (!resetn) begin
            bus.axi_arready_i = 1'b0;
            bus.axi_rvalid_i  = 1'b0;
            bus.axi_rlast_i   = 1'b0;
            bus.axi_rdata_i   = '0;
            ar_wait = 0; s_total = 0; s_idx = 0;
        end else begin
            if (ar_hs) begin
                bus.axi_arready_i = 1'b0;
                s_total = (cfg_beats != 0) ? cfg_beats : int'(cap_len) + 1;
                s_idx   = 0;
                s_addr  = cap_addr;
            end else if (bus.axi_arvalid_o && !bus.axi_arready_i) begin
                if (ar_wait >= cfg_ar_delay) begin
                    bus.axi_arready_i = 1'b1;
                    ar_wait = 0;
                end else begin
                    ar_wait++;
                end
            end
            if (r_hs) s_idx++;
            if (s_idx < s_total) begin
                bus.axi_rvalid_i = 1'b1;
                bus.axi_rdata_i  = s_addr + 32'(s_idx) * 32'd4;
                bus.axi_rlast_i  = (s_idx == s_total - 1);
            end else begin
                bus.axi_rvalid_i = 1'b0;
                bus.axi_rlast_i  = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_quiet(input int budget, input string tag);
        int n = 0;
        @(negedge clock);
        while ((busy || issued[0] != done[0] || issued[1] != done[1] || issued[2] != done[2])
               && n < budget) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_timeout"}, 64'(n >= budget), 64'd0);
    endtask

    task automatic wait_beats(input int m, input int target, input int budget, input string tag);
        int n = 0;
        while (beats[m] < target && n < budget) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_timeout"}, 64'(n >= budget), 64'd0);
    endtask

    int s_ar [3], s_bt [3], s_rl [3];
    int s_ord, s_stray, s_wait, s_unst, s_bad;

    task automatic snap();
        for (int m = 0; m < 3; m++) begin
            s_ar[m] = ar_cnt[m];
            s_bt[m] = beats[m];
            s_rl[m] = rlast_cnt[m];
        end
        s_ord = order_n; s_stray = stray; s_wait = ar_wait_cyc; s_unst = unstable; s_bad = bad_pulse;
    endtask

    initial begin
        bus.m_rready_i = 3'b111;
        for (int m = 0; m < 3; m++) begin
            req_addr[m] = '0;
            req_len[m]  = '0;
        end
        #2 resetn = 1'b0;
        repeat (3) @(negedge clock);

        // Reset state
        check("rst_grant",   64'(grant), 64'd0);
        check("rst_busy",    64'(busy), 64'd0);
        check("rst_err",     64'(err), 64'd0);
        check("rst_arvalid", 64'(bus.axi_arvalid_o), 64'd0);
        check("rst_rready",  64'(bus.axi_rready_o), 64'd0);
        check("rst_araddr",  64'(bus.axi_araddr_o), 64'd0);
        check("rst_arlen",   64'(bus.axi_arlen_o), 64'd0);
        check("rst_m_ar_rv", 64'({bus.m_arready_o, bus.m_rvalid_o}), 64'd0);
        check("rst_size_burst", 64'({bus.axi_arsize_o, bus.axi_arburst_o}), 64'b010_01);
        resetn = 1'b1;
        @(negedge clock);

        // Single M1 burst of 8 beats
        snap();
        req_addr[1] = 32'h1FC0_0020; req_len[1] = 4'd7; issued[1]++;
        wait_quiet(100, "a");
        check("a_araddr",    64'(cap_addr), 64'h1FC0_0020);
        check("a_arlen",     64'(cap_len), 64'd7);
        check("a_arready",   64'(ar_cnt[1] - s_ar[1]), 64'd1);
        check("a_beats",     64'(beats[1] - s_bt[1]), 64'd8);
        check("a_rlast_at",  64'(rlast_at[1]), 64'd8);
        check("a_rlast_cnt", 64'(rlast_cnt[1] - s_rl[1]), 64'd1);
        check("a_last_data", 64'(last_data[1]), 64'h1FC0_003C);
        check("a_other",     64'(beats[0] - s_bt[0] + beats[2] - s_bt[2]), 64'd0);
        check("a_grant_err", 64'({grant, err}), 64'd0);

        // All three request together
        snap();
        req_addr[0] = 32'h1000; req_len[0] = 4'd1;
        req_addr[1] = 32'h2000; req_len[1] = 4'd2;
        req_addr[2] = 32'h3000; req_len[2] = 4'd3;
        issued[0]++; issued[1]++; issued[2]++;
        wait_quiet(200, "b");
        check("b_order_n", 64'(order_n - s_ord), 64'd3);
        check("b_order0",  64'(order[s_ord]), 64'd0);
        check("b_order1",  64'(order[s_ord + 1]), 64'd1);
        check("b_order2",  64'(order[s_ord + 2]), 64'd2);
        check("b_beats",   64'({8'(beats[0] - s_bt[0]), 8'(beats[1] - s_bt[1]), 8'(beats[2] - s_bt[2])}),
                           64'h02_03_04);
        check("b_stray",   64'(stray - s_stray), 64'd0);
        check("b_data2",   64'(last_data[2]), 64'h300C);

        // AR stalled five cycles
        snap();
        cfg_ar_delay = 5;
        req_addr[0] = 32'h4000; req_len[0] = 4'd0; issued[0]++;
        wait_quiet(100, "c");
        cfg_ar_delay = 0;
        check("c_wait_cycles", 64'(ar_wait_cyc - s_wait), 64'd5);
        check("c_stable",      64'(unstable - s_unst), 64'd0);
        check("c_pulse",       64'(bad_pulse - s_bad), 64'd0);
        check("c_arready",     64'(ar_cnt[0] - s_ar[0]), 64'd1);
        check("c_araddr",      64'(cap_addr), 64'h4000);

        // Starvation: M0 back-to-back, M2 waiting
        snap();
        req_addr[0] = 32'h8000; req_len[0] = 4'd0;
        req_addr[2] = 32'h9000; req_len[2] = 4'd0;
        issued[0] += 10; issued[2]++;
        wait_quiet(400, "s");
        check("s_order_n", 64'(order_n - s_ord), 64'd11);
        check("s_m0_before", 64'(order[s_ord + 5]), 64'd0);
        check("s_m2_wins",   64'(order[s_ord + 6]), 64'd2);
        check("s_m0_resume", 64'(order[s_ord + 7]), 64'd0);
        check("s_m0_count",  64'(ar_cnt[0] - s_ar[0]), 64'd10);

        // Early rlast: 4 beats against arlen 7
        snap();
        check("d_err_pre", 64'(err), 64'd0);
        cfg_beats = 4;
        req_addr[1] = 32'h5000; req_len[1] = 4'd7; issued[1]++;
        wait_quiet(100, "d");
        cfg_beats = 0;
        check("d_err_short", 64'(err), 64'd1);
        check("d_idle",      64'({grant, busy}), 64'd0);
        check("d_beats",     64'(beats[1] - s_bt[1]), 64'd4);
        req_len[1] = 4'd1; issued[1]++;
        wait_quiet(100, "d2");
        check("d_err_sticky", 64'(err), 64'd1);
        @(negedge clock) resetn = 1'b0;
        @(negedge clock);
        check("d_err_reset", 64'(err), 64'd0);
        resetn = 1'b1;
        @(negedge clock);

        // Overlong burst: 9 beats against arlen 7
        snap();
        cfg_beats = 9;
        req_addr[1] = 32'h5100; req_len[1] = 4'd7; issued[1]++;
        wait_beats(1, s_bt[1] + 7, 100, "d3");
        check("d_err_beat7", 64'(err), 64'd0);
        wait_beats(1, s_bt[1] + 8, 20, "d4");
        check("d_err_beat8", 64'({err, busy}), 64'b11);
        wait_quiet(50, "d5");
        cfg_beats = 0;
        check("d_beats9", 64'(beats[1] - s_bt[1]), 64'd9);
        @(negedge clock) resetn = 1'b0;
        @(negedge clock) resetn = 1'b1;
        @(negedge clock);

        // Asynchronous reset in the middle of a read burst
        snap();
        req_addr[1] = 32'h6000; req_len[1] = 4'd7; issued[1]++;
        wait_beats(1, s_bt[1] + 3, 100, "e");
        #2 resetn = 1'b0;
        #1;
        check("e_grant_busy", 64'({grant, busy, err}), 64'd0);
        check("e_m_rvalid",   64'({bus.m_rvalid_o, bus.m_rlast_o, bus.m_arready_o}), 64'd0);
        check("e_axi_hs",     64'({bus.axi_arvalid_o, bus.axi_rready_o}), 64'd0);
        check("e_addr_len",   64'({bus.axi_araddr_o, bus.axi_arlen_o}), 64'd0);
        @(negedge clock) resetn = 1'b1;
        @(negedge clock);
        snap();
        req_addr[2] = 32'h7000; req_len[2] = 4'd2; issued[2]++;
        wait_quiet(100, "e2");
        check("e_m2_ar",    64'(ar_cnt[2] - s_ar[2]), 64'd1);
        check("e_m2_addr",  64'(cap_addr), 64'h7000);
        check("e_m2_beats", 64'(beats[2] - s_bt[2]), 64'd3);
        check("e_m2_last",  64'({8'(rlast_at[2]), last_data[2]}), 64'h03_0000_7008);
        check("e_err",      64'({err, grant}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
